// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared branch-type encodings and default widths for the PC sequencer
package pc_pkg;

  localparam int DEF_PC_W      = 16;
  localparam int DEF_COND_W    = 8;
  localparam int DEF_UNCOND_W  = 11;
  localparam int DEF_LINK_W    = 6;
  localparam int DEF_RAS_DEPTH = 4;

  localparam logic [1:0] BR_COND   = 2'b00;
  localparam logic [1:0] BR_UNCOND = 2'b01;
  localparam logic [1:0] BR_CALL   = 2'b10;
  localparam logic [1:0] BR_RET    = 2'b11;

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - branch-resolution bundle from EX into the PC sequencer
interface pc_sequencer_if #(
  parameter int PC_W     = pc_pkg::DEF_PC_W,
  parameter int COND_W   = pc_pkg::DEF_COND_W,
  parameter int UNCOND_W = pc_pkg::DEF_UNCOND_W,
  parameter int LINK_W   = pc_pkg::DEF_LINK_W
);
  logic                branch_valid;
  logic [1:0]          branch_type;
  logic                BrTaken;
  logic                reg_branch;
  logic [PC_W-1:0]     branch_pc;
  logic [COND_W-1:0]   cond_address;
  logic [UNCOND_W-1:0] uncond_address;
  logic [LINK_W-1:0]   link_address;
  logic [PC_W-1:0]     register_data_2;

  modport master (
    output branch_valid, branch_type, BrTaken, reg_branch, branch_pc,
           cond_address, uncond_address, link_address, register_data_2
  );

  modport slave (
    input branch_valid, branch_type, BrTaken, reg_branch, branch_pc,
          cond_address, uncond_address, link_address, register_data_2
  );
endinterface

// File: rtl/pc_sequencer_ras.sv
// rtl/pc_sequencer_ras.sv - circular return-address stack; a push when full overwrites the oldest entry
module return_addr_stack #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         overflow
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // ptr_q is the next write slot; when full it also addresses the oldest entry
  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             full;

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    full  = (cnt_q == CNT_W'(DEPTH));
    if (push) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (full) ovf_d = 1'b1;
      else      cnt_d = cnt_q + CNT_W'(1);
    end else if (pop && cnt_q != '0) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push) mem_q[ptr_q] <= push_data;
  end

  assign top      = mem_q[ptr_q - PTR_W'(1)];
  assign empty    = (cnt_q == '0);
  assign overflow = ovf_q;
endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC register with branch redirect, stall hold and RAS-backed returns
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int          PC_W      = DEF_PC_W,
  parameter int          COND_W    = DEF_COND_W,
  parameter int          UNCOND_W  = DEF_UNCOND_W,
  parameter int          LINK_W    = DEF_LINK_W,
  parameter int          RAS_DEPTH = DEF_RAS_DEPTH,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  pc_sequencer_if.slave    br,
  output logic [PC_W-1:0]  pc_out,
  output logic [PC_W-1:0]  link_pc,
  output logic             flush,
  output logic             ras_empty,
  output logic             ras_overflow
);
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] link_q, link_d;
  logic            flush_q;
  logic            redirect;
  logic            push, pop;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] ras_top;
  logic [PC_W-1:0] ret_addr;

  assign ret_addr = br.branch_pc + PC_W'(1);
  assign push     = br.branch_valid && (br.branch_type == BR_CALL);
  assign pop      = br.branch_valid && (br.branch_type == BR_RET);
  assign redirect = br.branch_valid && ((br.branch_type != BR_COND) || br.BrTaken);

  always_comb begin
    target = '0;
    case (br.branch_type)
      BR_COND:   target = br.branch_pc
                        + {{(PC_W-COND_W){br.cond_address[COND_W-1]}}, br.cond_address};
      BR_UNCOND: target = br.branch_pc
                        + {{(PC_W-UNCOND_W){br.uncond_address[UNCOND_W-1]}}, br.uncond_address};
      BR_CALL:   target = {{(PC_W-LINK_W){1'b0}}, br.link_address};
      default:   target = ras_empty ? br.register_data_2 : ras_top;
    endcase
    // a register target never replaces the RAS prediction for returns
    if (br.reg_branch && br.branch_type != BR_RET) target = br.register_data_2;
  end

  always_comb begin
    pc_d   = pc_q + PC_W'(1);
    link_d = link_q;
    if (redirect)   pc_d = target;
    else if (stall) pc_d = pc_q;
    if (push) link_d = ret_addr;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q    <= PC_W'(RESET_PC);
      link_q  <= '0;
      flush_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      link_q  <= link_d;
      flush_q <= redirect;
    end
  end

  return_addr_stack #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (ret_addr),
    .top       (ras_top),
    .empty     (ras_empty),
    .overflow  (ras_overflow)
  );

  assign pc_out  = pc_q;
  assign link_pc = link_q;
  assign flush   = flush_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed checks of the PC sequencer with hand-computed expectations
module tb_pc_sequencer;
  import pc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [15:0] pc_out, link_pc;
  logic        flush, ras_empty, ras_overflow;
  int          errors = 0;
  int          checks = 0;

  pc_sequencer_if br ();

  pc_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .br           (br.slave),
    .pc_out       (pc_out),
    .link_pc      (link_pc),
    .flush        (flush),
    .ras_empty    (ras_empty),
    .ras_overflow (ras_overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    br.branch_valid = 1'b0;
    br.branch_type  = BR_COND;
    br.BrTaken      = 1'b0;
    br.reg_branch   = 1'b0;
  endtask

  task automatic branch(input logic [1:0] t, input logic taken, input logic [15:0] bpc);
    br.branch_valid = 1'b1;
    br.branch_type  = t;
    br.BrTaken      = taken;
    br.branch_pc    = bpc;
  endtask

  initial begin
    reset = 1'b0;
    stall = 1'b0;
    idle();
    br.branch_pc       = '0;
    br.cond_address    = '0;
    br.uncond_address  = '0;
    br.link_address    = '0;
    br.register_data_2 = '0;
    tick();
    tick();
    chk("rst_pc", pc_out, 0);
    chk("rst_link", link_pc, 0);
    chk("rst_flush", flush, 0);
    chk("rst_empty", ras_empty, 1);
    chk("rst_ovf", ras_overflow, 0);

    reset = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("seq_pc", pc_out, i);
    end
    reset = 1'b0;
    tick();
    chk("mid_reset_pc", pc_out, 0);
    reset = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("seq2_pc", pc_out, i);
    end
    chk("seq_flush", flush, 0);

    br.cond_address = 8'hFC;
    branch(BR_COND, 1'b1, 16'h0010);
    tick();
    chk("cond_taken_pc", pc_out, 16'h000C);
    chk("cond_taken_flush", flush, 1);
    idle();
    tick();
    chk("cond_after_pc", pc_out, 16'h000D);
    chk("cond_after_flush", flush, 0);
    branch(BR_COND, 1'b0, 16'h0010);
    tick();
    chk("cond_nt_pc", pc_out, 16'h000E);
    chk("cond_nt_flush", flush, 0);

    br.link_address = 6'h2A;
    branch(BR_CALL, 1'b0, 16'h0100);
    tick();
    chk("call_pc", pc_out, 16'h002A);
    chk("call_link", link_pc, 16'h0101);
    chk("call_empty", ras_empty, 0);
    chk("call_flush", flush, 1);
    idle();
    tick();
    chk("call_seq_pc", pc_out, 16'h002B);
    br.register_data_2 = 16'h0777;
    branch(BR_RET, 1'b0, 16'h002B);
    tick();
    chk("ret_pc", pc_out, 16'h0101);
    chk("ret_empty", ras_empty, 1);

    for (int i = 1; i <= 5; i++) begin
      branch(BR_CALL, 1'b0, 16'(i));
      tick();
      chk("ovf_call_ovf", ras_overflow, (i == 5) ? 1 : 0);
    end
    chk("ovf_link", link_pc, 16'h0006);
    chk("ovf_pc", pc_out, 16'h002A);
    for (int i = 0; i < 4; i++) begin
      branch(BR_RET, 1'b0, 16'h0040);
      tick();
      chk("ovf_ret_pc", pc_out, 16'(6 - i));
    end
    chk("ovf_drained_empty", ras_empty, 1);
    tick();
    chk("ret_fallback_pc", pc_out, 16'h0777);
    chk("ret_fallback_empty", ras_empty, 1);
    chk("ovf_sticky", ras_overflow, 1);
    idle();

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", pc_out, 16'h0777);
    end
    chk("stall_flush", flush, 0);
    br.uncond_address = 11'd8;
    branch(BR_UNCOND, 1'b0, 16'h0020);
    tick();
    chk("stall_redirect_pc", pc_out, 16'h0028);
    chk("stall_redirect_flush", flush, 1);
    idle();
    tick();
    chk("stall_hold_pc", pc_out, 16'h0028);
    stall = 1'b0;
    tick();
    chk("unstall_pc", pc_out, 16'h0029);

    br.register_data_2 = 16'h1234;
    br.reg_branch      = 1'b1;
    br.branch_valid    = 1'b1;
    br.branch_type     = BR_COND;
    br.BrTaken         = 1'b1;
    tick();
    chk("regbr_pc", pc_out, 16'h1234);
    idle();

    br.uncond_address = 11'h00F;
    branch(BR_UNCOND, 1'b0, 16'hFFF0);
    tick();
    chk("to_ffff_pc", pc_out, 16'hFFFF);
    idle();
    tick();
    chk("wrap_pc", pc_out, 16'h0000);

    br.cond_address = 8'h7F;
    branch(BR_COND, 1'b1, 16'hFFF0);
    tick();
    chk("cond_wrap_pos", pc_out, 16'h006F);
    br.cond_address = 8'h80;
    branch(BR_COND, 1'b1, 16'h0002);
    tick();
    chk("cond_wrap_neg", pc_out, 16'hFF82);
    br.uncond_address = 11'h400;
    branch(BR_UNCOND, 1'b0, 16'h0400);
    tick();
    chk("uncond_neg", pc_out, 16'h0000);

    reset = 1'b0;
    branch(BR_CALL, 1'b0, 16'h0050);
    tick();
    chk("rst_call_pc", pc_out, 0);
    chk("rst_call_link", link_pc, 0);
    chk("rst_call_empty", ras_empty, 1);
    chk("rst_call_ovf", ras_overflow, 0);
    chk("rst_call_flush", flush, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
